// File: rtl/cam_capture_rgb444_pkg.sv
// Shared geometry, pixel type and capture state encoding for the camera capture
// path. The video timing generator imports the same constants so the frame-buffer
// writer and reader agree on the layout (address = y*H_ACTIVE + x).
package cam_capture_rgb444_pkg;

    localparam int unsigned H_ACTIVE_DEF    = 320;
    localparam int unsigned V_ACTIVE_DEF    = 240;
    localparam int unsigned ADDR_W_DEF      = 17;
    localparam int unsigned SKIP_FRAMES_DEF = 2;
    localparam int unsigned FB_DEPTH        = H_ACTIVE_DEF * V_ACTIVE_DEF;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        StSkip,
        StWait,
        StCapture
    } cap_state_e;

    // a_bits = {A[7:4], A[2:0]}, b_bits = {B[7], B[4:1]} of an RGB565 byte pair.
    function automatic rgb444_t pack_rgb444(input logic [6:0] a_bits, input logic [4:0] b_bits);
        rgb444_t px;
        px.r = a_bits[6:3];
        px.g = {a_bits[2:0], b_bits[4]};
        px.b = b_bits[3:0];
        return px;
    endfunction

endpackage

// File: rtl/cam_capture_rgb444_if.sv
// Camera input and frame-buffer write bundle.
//   cam_vsync/cam_href/cam_data : sensor side (into the capture block)
//   wr_en/wr_addr/wr_data       : frame-buffer write port (out of the capture block)
//   frame_done/frame_err        : end-of-frame strobe and integrity flag
// master = capture block, slave = sensor/frame-buffer side.
interface cam_capture_rgb444_if
    import cam_capture_rgb444_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              frame_done;
    logic              frame_err;

    modport master (
        input  cam_vsync, cam_href, cam_data,
        output wr_en, wr_addr, wr_data, frame_done, frame_err
    );

    modport slave (
        output cam_vsync, cam_href, cam_data,
        input  wr_en, wr_addr, wr_data, frame_done, frame_err
    );

endinterface

// File: rtl/cam_capture_rgb444_sync_edge.sv
// Registers a camera control input once (q_o) and flags its edges against a
// second register stage.
//   clk, rst : pixel clock, async active-high reset
//   d_i      : raw input
//   q_o      : first register stage
//   rise_o   : one-cycle pulse, q_o went 0->1
//   fall_o   : one-cycle pulse, q_o went 1->0
module cam_capture_rgb444_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic q_q, q_d;
    logic q2_q, q2_d;

    always_comb begin
        q_d  = d_i;
        q2_d = q_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q  <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            q2_q <= q2_d;
        end
    end

    assign q_o    = q_q;
    assign rise_o = q_q & ~q2_q;
    assign fall_o = ~q_q & q2_q;

endmodule

// File: rtl/cam_capture_rgb444.sv
// OV7670-style RGB565 capture: pairs bytes into RGB444 pixels and writes them
// linearly into the frame buffer, with per-line/per-frame integrity checking.
//   clk, rst : camera PCLK, async active-high reset
//   bus      : master side of cam_capture_rgb444_if (sensor in, frame-buffer
//              write port, frame_done/frame_err out)
module cam_capture_rgb444
    import cam_capture_rgb444_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned SKIP_FRAMES = SKIP_FRAMES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    cam_capture_rgb444_if.master  bus
);

    localparam int unsigned FbDepth = H_ACTIVE * V_ACTIVE;
    // One extra bit so the counter can reach FbDepth == 2**ADDR_W without wrapping.
    localparam logic [ADDR_W:0] FbDepthW = (ADDR_W + 1)'(FbDepth);
    localparam logic [15:0]     HActiveW = 16'(H_ACTIVE);
    localparam logic [9:0]      VActiveW = 10'(V_ACTIVE);
    localparam logic [7:0]      SkipTgt  = 8'(SKIP_FRAMES);

    logic vs_q, vs_rise, vs_fall;
    logic href_q, href_rise, href_fall;

    cam_capture_rgb444_sync_edge u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.cam_vsync),
        .q_o    (vs_q),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    cam_capture_rgb444_sync_edge u_href_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.cam_href),
        .q_o    (href_q),
        .rise_o (href_rise),
        .fall_o (href_fall)
    );

    cap_state_e        state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        skip_cnt_q, skip_cnt_d;
    logic [15:0]       pix_cnt_q, pix_cnt_d;
    logic [9:0]        line_cnt_q, line_cnt_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              phase_q, phase_d;
    logic [6:0]        a_bits_q, a_bits_d;
    logic              err_acc_q, err_acc_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    rgb444_t           wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic              line_end;
    logic              line_err;

    always_comb begin
        state_d      = state_q;
        data_d       = bus.cam_data;
        skip_cnt_d   = skip_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        addr_d       = addr_q;
        phase_d      = phase_q;
        a_bits_d     = a_bits_q;
        err_acc_d    = err_acc_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
        line_end     = 1'b0;
        line_err     = 1'b0;

        unique case (state_q)
            StSkip: begin
                if (SkipTgt == 8'd0) begin
                    state_d = StWait;
                end else if (vs_rise) begin
                    skip_cnt_d = skip_cnt_q + 8'd1;
                    if (skip_cnt_d == SkipTgt) begin
                        state_d = StWait;
                    end
                end
            end

            StWait: begin
                if (vs_fall) begin
                    state_d    = StCapture;
                    addr_d     = '0;
                    line_cnt_d = '0;
                    pix_cnt_d  = '0;
                    phase_d    = 1'b0;
                    err_acc_d  = 1'b0;
                end
            end

            StCapture: begin
                // A vsync rise with href still high closes the line first, so the
                // line checks land in the accumulator before the frame snapshot.
                line_end = href_fall | (vs_rise & href_q);
                if (line_end) begin
                    if (phase_q || (pix_cnt_q != HActiveW)) begin
                        line_err = 1'b1;
                    end
                    err_acc_d = err_acc_q | line_err;
                    phase_d   = 1'b0;
                    pix_cnt_d = '0;
                    if (line_cnt_q != '1) begin
                        line_cnt_d = line_cnt_q + 10'd1;
                    end
                end else if (href_rise) begin
                    // Start of line: byte phase is 0 by construction; latch byte A.
                    a_bits_d = {data_q[7:4], data_q[2:0]};
                    phase_d  = 1'b1;
                end else if (href_q && !vs_q) begin
                    if (!phase_q) begin
                        a_bits_d = {data_q[7:4], data_q[2:0]};
                        phase_d  = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (pix_cnt_q != '1) begin
                            pix_cnt_d = pix_cnt_q + 16'd1;
                        end
                        if (addr_q < FbDepthW) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q[ADDR_W-1:0];
                            wr_data_d = pack_rgb444(a_bits_q, {data_q[7], data_q[4:1]});
                            addr_d    = addr_q + (ADDR_W + 1)'(1);
                        end else begin
                            // Frame overran the buffer: drop the pixel, never wrap.
                            err_acc_d = 1'b1;
                        end
                    end
                end

                if (vs_rise) begin
                    state_d      = StWait;
                    frame_done_d = 1'b1;
                    frame_err_d  = err_acc_d | (line_cnt_d != VActiveW);
                end
            end

            default: state_d = StSkip;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StSkip;
            data_q       <= '0;
            skip_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            addr_q       <= '0;
            phase_q      <= 1'b0;
            a_bits_q     <= '0;
            err_acc_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            skip_cnt_q   <= skip_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            addr_q       <= addr_d;
            phase_q      <= phase_d;
            a_bits_q     <= a_bits_d;
            err_acc_q    <= err_acc_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;

endmodule
